// File: rtl/pattern_editor.sv
// Cursor-driven editor for the 4x16 beat pattern: wrapping cursor with auto-repeat, cell toggle,
// four-cycle clear sweep, and a req/ack redraw request towards the draw control.
module pattern_editor #(
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        key_left_i,
    input  logic        key_right_i,
    input  logic        key_up_i,
    input  logic        key_down_i,
    input  logic        key_toggle_i,
    input  logic        key_clear_i,
    input  logic        draw_ack_i,
    output logic [15:0] pattern1_o,
    output logic [15:0] pattern2_o,
    output logic [15:0] pattern3_o,
    output logic [15:0] pattern4_o,
    output logic [3:0]  cursor_col_o,
    output logic [1:0]  cursor_row_o,
    output logic        draw_req_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;
    typedef enum logic [2:0] {DirNone, DirLeft, DirRight, DirUp, DirDown} dir_e;

    localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][15:0] pat_q, pat_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [5:0]       keys_prev_q;
    dir_e             rep_dir_q, rep_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             pend_q, pend_d;

    logic [5:0] keys, press;
    dir_e       win_dir, move_dir;
    logic       win_press, sweep, changed;

    assign keys  = {key_clear_i, key_toggle_i, key_down_i, key_up_i, key_right_i, key_left_i};
    assign press = keys & ~keys_prev_q;

    // Only the highest-priority held direction key counts, and only its own press edge moves.
    always_comb begin
        win_dir   = DirNone;
        win_press = 1'b0;
        if (key_left_i) begin
            win_dir   = DirLeft;
            win_press = press[0];
        end else if (key_right_i) begin
            win_dir   = DirRight;
            win_press = press[1];
        end else if (key_up_i) begin
            win_dir   = DirUp;
            win_press = press[2];
        end else if (key_down_i) begin
            win_dir   = DirDown;
            win_press = press[3];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        col_d     = col_q;
        row_d     = row_q;
        rep_dir_d = rep_dir_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        move_dir  = DirNone;
        sweep     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press[5]) begin
                    state_d   = StClear;
                    idx_d     = 2'd0;
                    rep_dir_d = DirNone;
                    cnt_d     = '0;
                    phase_d   = 1'b0;
                    sweep     = 1'b1;
                end else begin
                    if (win_press) begin
                        move_dir  = win_dir;
                        rep_dir_d = win_dir;
                        cnt_d     = '0;
                        phase_d   = 1'b0;
                    end else if (win_dir != DirNone && win_dir == rep_dir_q) begin
                        if (cnt_q == (phase_q ? RateLast : DelayLast)) begin
                            move_dir = win_dir;
                            cnt_d    = '0;
                            phase_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end else begin
                        rep_dir_d = DirNone;
                        cnt_d     = '0;
                        phase_d   = 1'b0;
                    end
                    // Toggle addresses the pre-move cursor.
                    if (press[4]) begin
                        pat_d[row_q][col_q] = ~pat_q[row_q][col_q];
                    end
                    case (move_dir)
                        DirLeft:  col_d = col_q - 4'd1;
                        DirRight: col_d = col_q + 4'd1;
                        DirUp:    row_d = row_q - 2'd1;
                        DirDown:  row_d = row_q + 2'd1;
                        default:  ;
                    endcase
                end
            end
            StClear: begin
                pat_d[idx_q] = 16'h0000;
                idx_d        = idx_q + 2'd1;
                rep_dir_d    = DirNone;
                cnt_d        = '0;
                phase_d      = 1'b0;
                sweep        = 1'b1;
                if (idx_q == 2'd3) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A sweep counts as a change every cycle so an early ack cannot drop the request.
    assign changed = sweep || (pat_d != pat_q) || (col_d != col_q) || (row_d != row_q);
    assign pend_d  = changed ? 1'b1 : (draw_ack_i ? 1'b0 : pend_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            pat_q       <= '0;
            col_q       <= 4'd0;
            row_q       <= 2'd0;
            keys_prev_q <= 6'h3f;
            rep_dir_q   <= DirNone;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pat_q       <= pat_d;
            col_q       <= col_d;
            row_q       <= row_d;
            keys_prev_q <= keys;
            rep_dir_q   <= rep_dir_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
        end
    end

    assign pattern1_o   = pat_q[0];
    assign pattern2_o   = pat_q[1];
    assign pattern3_o   = pat_q[2];
    assign pattern4_o   = pat_q[3];
    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;
    assign draw_req_o   = pend_q;
    assign busy_o       = (state_q == StClear);

endmodule

// File: doc/pattern_editor.md
Name: pattern_editor

Overview:
- Cursor-driven editor that owns the 4-row x 16-column beat pattern and writes it. It is the writer side of the pattern interface that the grid-draw datapath reads as four 16-bit rows.
- Takes already-synchronised push-button levels. Moves a wrapping cursor, toggles cells, and clears the whole pattern with a multi-cycle sweep.
- Raises a req/ack redraw request to the draw control whenever the pattern or cursor changes.

Parameters:
- REPEAT_DELAY, 8'd50 (scaled per board; 25_000_000 on hardware), cycles a direction key must be held before the first auto-repeat.
- REPEAT_RATE, 8'd10 (hardware 6_250_000), cycles between subsequent auto-repeats.
- CNT_W, 25, width of the hold counter; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- keyLeft  in  1  level, active-high: move cursor left.
- keyRight  in  1  level, active-high: move cursor right.
- keyUp  in  1  level, active-high: move cursor up.
- keyDown  in  1  level, active-high: move cursor down.
- keyToggle  in  1  level, active-high: invert cell under cursor.
- keyClear  in  1  level, active-high: clear entire pattern.
- drawAck  in  1  draw control has accepted the redraw request.
- pattern1, pattern2, pattern3, pattern4  out  16 each  rows 0..3; bit n = column n.
- cursorCol  out  4  cursor column 0..15.
- cursorRow  out  2  cursor row 0..3.
- drawReq  out  1  redraw pending.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (sync, any state, including mid-sweep):
  - patterns = 0; cursor = (row 0, col 0); busy = 0; state = IDLE.
  - drawReq = 1, forcing the initial screen draw.
  - Key-previous registers = 1, so keys held through reset generate no press.
  - Hold counter = 0.
- Press event: key & ~keyPrev. keyPrev updates every cycle.
- Direction priority when several direction keys are active: Left > Right > Up > Down. Only the winning key is acted on and counted.
- Cursor moves (registered, visible the cycle after the event):
  - Right: col 15 -> 0. Left: col 0 -> 15.
  - Down: row 3 -> 0. Up: row 0 -> 3.
  - Column and row wrap independently; there is no carry between them.
- Auto-repeat (direction keys only):
  - Hold counter clears on the press cycle and increments while the same key stays high.
  - First repeat move fires REPEAT_DELAY cycles after the press cycle.
  - Further repeats fire every REPEAT_RATE cycles after that.
  - Release, or a change of winning key, clears the counter and the repeat phase.
- Toggle: on a keyToggle press, invert pattern[cursorRow][cursorCol]. No auto-repeat.
  - If a move occurs in the same cycle, the toggle uses the pre-move cursor, and the move also takes effect.
- State machine:
  - IDLE: a keyClear press -> CLEAR, with sweep index 0 and busy = 1 from the next cycle.
  - CLEAR: clears row index k on cycle k (k = 0..3). After row 3 -> IDLE, busy = 0. Sweep lasts exactly 4 cycles.
  - keyClear takes precedence over toggle and move in the same cycle; those are discarded.
  - During CLEAR, all key events are discarded, the hold counter is held at 0, and keyPrev keeps tracking.
  - Cursor position is preserved through a clear.
- Redraw handshake:
  - Any cycle that changes a pattern bit or the cursor sets a pending flag. drawReq = pending.
  - pending clears on a cycle where drawAck = 1 and no new change occurs.
  - A change in the same cycle as drawAck keeps drawReq = 1.
  - A CLEAR sweep raises drawReq once; it stays high until acked after the sweep.
  - drawAck while drawReq = 0 is ignored.
- All outputs are registered, with no combinational path from key inputs to outputs.

Test Plan:
1. Hold keyRight through reset, release reset, keep holding 3 cycles -> no move, cursorCol = 0. drawReq = 1 until drawAck pulsed, then 0.
2. REPEAT_DELAY = 8, REPEAT_RATE = 3. Press keyRight at cycle 0 and hold 20 cycles.
   - Moves on cycles 0, 8, 11, 14, 17, 20; cursorCol = 6 after release.
   - From col 15, a single press -> col 0.
   - keyUp at row 0 -> row 3.
3. Cursor (row 2, col 5). Press keyToggle -> pattern3 = 16'h0020. Press again -> 16'h0000.
   - keyToggle + keyRight in the same cycle -> pattern3 = 16'h0020, cursorCol = 6.
4. Load all rows to 16'hFFFF, press keyClear.
   - busy = 1 for exactly 4 cycles; pattern1..4 become 0 on successive cycles.
   - keyToggle pulsed during the sweep has no effect; cursor unchanged.
5. Assert reset on the second cycle of a clear sweep -> next cycle all patterns 0, busy = 0, cursor (0,0), drawReq = 1.
6. Hold drawAck = 1 while pressing keyLeft each cycle for 3 cycles -> drawReq stays 1. Release keys with drawAck = 1 -> drawReq = 0 the following cycle.
